// File: rtl/zp_sub_array.sv
// Per-lane subtraction of a per-channel zero point, saturated or truncated to OUT_W; 2-cycle latency.
// One advance enable: a held output freezes both stages and drops in_ready.
module zp_sub_array #(
  parameter int DATA_W = 4,
  parameter int OUT_W  = 5,
  parameter int LANES  = 4,
  parameter int CH     = 4,
  parameter int SAT_EN = 1,
  localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_addr,
  input  logic [DATA_W-1:0]        cfg_zp,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic [LANES*DATA_W-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   out_data,
  output logic [LANES-1:0]         out_sat,
  output logic [15:0]              beat_cnt
);

  localparam int DW = DATA_W + 1;

  logic                     en;
  logic [DATA_W-1:0]        zp_tab [CH];
  logic [DATA_W-1:0]        zp_rd;
  logic                     s1_vld;
  logic [LANES*DATA_W-1:0]  s1_data;
  logic [DATA_W-1:0]        s1_zp;
  logic [LANES*OUT_W-1:0]   nxt_data;
  logic [LANES-1:0]         nxt_sat;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Read happens before this edge's table write lands, so a same-cycle write is seen only by later beats.
  always_comb begin
    zp_rd = '0;
    if (32'(in_ch) < CH) zp_rd = zp_tab[in_ch];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) zp_tab[i] <= '0;
    end else if (cfg_we && (32'(cfg_addr) < CH)) begin
      zp_tab[cfg_addr] <= cfg_zp;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DATA_W-1:0]    a;
    logic signed [DW-1:0] d;

    assign a = s1_data[l*DATA_W +: DATA_W];
    assign d = $signed({a[DATA_W-1], a}) - $signed({s1_zp[DATA_W-1], s1_zp});

    if (OUT_W >= DW) begin : g_wide
      assign nxt_data[l*OUT_W +: OUT_W] = OUT_W'(d);
      assign nxt_sat[l]                 = 1'b0;
    end else begin : g_narrow
      logic ovf;
      // Representable only when all dropped bits match the new sign bit.
      assign ovf = !((&d[DW-1:OUT_W-1]) || !(|d[DW-1:OUT_W-1]));
      assign nxt_sat[l] = ovf;
      if (SAT_EN != 0) begin : g_sat
        assign nxt_data[l*OUT_W +: OUT_W] = !ovf ? d[OUT_W-1:0] :
                                            (d[DW-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                     : {1'b0, {(OUT_W-1){1'b1}}});
      end else begin : g_trunc
        assign nxt_data[l*OUT_W +: OUT_W] = d[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_data   <= '0;
      s1_zp     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else if (en) begin
      s1_vld    <= in_valid;
      s1_data   <= in_data;
      s1_zp     <= zp_rd;
      out_valid <= s1_vld;
      out_data  <= nxt_data;
      out_sat   <= nxt_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end

endmodule
